// File: rtl/servo_frame_scheduler.sv
// servo_frame_scheduler
// Multi-channel PPM-style servo pulse scheduler. One tick divider and one
// width timer are shared by all channels; channels fire back-to-back at the
// start of each fixed-length frame. Positions are written into shadow
// registers and copied atomically into the active set at each frame start.
module servo_frame_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int TICK_DIV    = 39,
    parameter int MIN_TICKS   = 256,
    parameter int FRAME_TICKS = 5120
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] servo_out,
    output logic              frame_start,
    output logic [2:0]        active_ch,
    output logic              busy
);

    // Counter widths; the divider keeps at least one bit so TICK_DIV=1 works.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WID_W = $clog2(MIN_TICKS + 256);
    localparam int FRM_W = $clog2(FRAME_TICKS * TICK_DIV + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_TICKS * TICK_DIV - 1);
    localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    // All pulses must fit inside one frame, otherwise the schedule overruns.
    if ((NUM_CH < 1) || (NUM_CH > 8) || (TICK_DIV < 1) ||
        (NUM_CH * (MIN_TICKS + 255) >= FRAME_TICKS)) begin : g_bad_cfg
        $fatal(1, "servo_frame_scheduler: illegal parameter set");
    end

    logic [1:0]        state_q, state_d;
    logic [2:0]        ch_q, ch_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [WID_W-1:0]  wid_q, wid_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              load_en;

    logic [7:0]        shadow_q [NUM_CH];
    logic [7:0]        active_q [NUM_CH];

    logic [NUM_CH-1:0] servo_q, servo_d;
    logic              fs_q, fs_d;
    logic [2:0]        ach_q, ach_d;
    logic              busy_q, busy_d;

    logic [7:0]        cur_pos;
    logic [WID_W-1:0]  wid_last;
    logic              div_tc;
    logic              pulse_done;
    logic              frame_end;

    // Select the latched position of the channel currently being timed.
    always_comb begin
        cur_pos = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == 3'(i)) begin
                cur_pos = active_q[i];
            end
        end
    end

    assign wid_last   = WID_W'(MIN_TICKS) + WID_W'(cur_pos) - WID_W'(1);
    assign div_tc     = (div_q == DIV_LAST);
    assign pulse_done = div_tc && (wid_q == wid_last);
    assign frame_end  = (frm_q == FRM_LAST);

    // Sequencer next-state: frame counter value k-1 marks the k-th cycle of
    // the frame, the LOAD cycle being the first.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        div_d   = div_q;
        wid_d   = wid_q;
        frm_d   = frm_q;
        load_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                ch_d  = '0;
                div_d = '0;
                wid_d = '0;
                frm_d = '0;
                if (enable) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load_en = 1'b1;
                ch_d    = '0;
                div_d   = '0;
                wid_d   = '0;
                frm_d   = FRM_W'(1);
                state_d = S_PULSE;
            end
            S_PULSE: begin
                frm_d = frm_q + FRM_W'(1);
                if (div_tc) begin
                    div_d = '0;
                    wid_d = wid_q + WID_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                if (pulse_done) begin
                    wid_d = '0;
                    if (ch_q == LAST_CH) begin
                        ch_d = '0;
                        // With TICK_DIV=1 the last pulse may close the frame itself.
                        if (frame_end) begin
                            frm_d   = '0;
                            state_d = enable ? S_LOAD : S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        ch_d = ch_q + 3'd1;
                    end
                end
            end
            S_WAIT: begin
                div_d = '0;
                wid_d = '0;
                frm_d = frm_q + FRM_W'(1);
                if (frame_end) begin
                    frm_d   = '0;
                    state_d = enable ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the pins come straight off flops.
    always_comb begin
        servo_d = '0;
        ach_d   = '0;
        if (state_d == S_PULSE) begin
            servo_d = NUM_CH'(1) << ch_d;
            ach_d   = ch_d;
        end
        fs_d   = (state_d == S_LOAD);
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer state, shared counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            div_q   <= '0;
            wid_q   <= '0;
            frm_q   <= '0;
            servo_q <= '0;
            fs_q    <= 1'b0;
            ach_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            div_q   <= div_d;
            wid_q   <= wid_d;
            frm_q   <= frm_d;
            servo_q <= servo_d;
            fs_q    <= fs_d;
            ach_q   <= ach_d;
            busy_q  <= busy_d;
        end
    end

    // Shadow positions; out-of-range channel indices match no register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ch == 3'(i)) begin
                    shadow_q[i] <= wr_data;
                end
            end
        end
    end

    // Active positions: snapshot of the pre-edge shadow set in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_q[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    assign servo_out   = servo_q;
    assign frame_start = fs_q;
    assign active_ch   = ach_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed testbench for servo_frame_scheduler with small timing parameters
// (TICK_DIV=2, MIN_TICKS=4, FRAME_TICKS=1100, NUM_CH=4 -> 2200-cycle frame).
module tb_servo_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_ch;
    logic [7:0] wr_data;
    logic [3:0] servo_out;
    logic       frame_start;
    logic [2:0] active_ch;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wid [4];

    servo_frame_scheduler #(
        .NUM_CH     (4),
        .TICK_DIV   (2),
        .MIN_TICKS  (4),
        .FRAME_TICKS(1100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .servo_out  (servo_out),
        .frame_start(frame_start),
        .active_ch  (active_ch),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic write_pos(input logic [2:0] ch, input logic [7:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_fs(input int bound, output int t, output bit found);
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                t     = cyc;
            end
        end
    endtask

    // Called at the negedge where frame_start is seen; times every channel.
    task automatic measure_frame(input int drop_ch);
        int         cnt;
        int         bad_ac;
        int         extra_fs;
        logic [3:0] bit_v;
        bad_ac   = 0;
        extra_fs = 0;
        @(negedge clk);
        wr_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bit_v = 4'b0001 << c;
            cnt   = 0;
            while (servo_out == bit_v && cnt < 2000) begin
                if (active_ch != 3'(c)) bad_ac++;
                if (frame_start) extra_fs++;
                if (c == drop_ch && cnt == 1) enable = 1'b0;
                cnt++;
                @(negedge clk);
            end
            wid[c] = cnt;
        end
        chk("servo_low_after_ch3", servo_out, 0);
        chk("active_ch_sequence_errors", bad_ac, 0);
        chk("frame_start_extra", extra_fs, 0);
    endtask

    task automatic chk_widths(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
        chk($sformatf("%s_w0", tag), wid[0], e0);
        chk($sformatf("%s_w1", tag), wid[1], e1);
        chk($sformatf("%s_w2", tag), wid[2], e2);
        chk($sformatf("%s_w3", tag), wid[3], e3);
    endtask

    initial begin
        int t0, t1, t2, t3, t_idle, t5, cnt;
        bit found;

        rst_n   = 1'b0;
        enable  = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_data = '0;

        // Reset state and idle after release with enable low
        repeat (3) @(negedge clk);
        chk("rst_servo", servo_out, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active_ch", active_ch, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_servo", servo_out, 0);
        chk("idle_fs", frame_start, 0);

        // Single frame widths: positions 0,1,255,10
        write_pos(3'd0, 8'd0);
        write_pos(3'd1, 8'd1);
        write_pos(3'd2, 8'd255);
        write_pos(3'd3, 8'd10);
        enable = 1'b1;
        wait_fs(10, t0, found);
        chk("fs1_seen", found, 1);
        measure_frame(-1);
        chk_widths("f1", 8, 10, 518, 28);

        // Frame period, plus a ch1 write landing in the LOAD cycle
        wait_fs(2500, t1, found);
        chk("fs2_seen", found, 1);
        chk("period_f1_f2", t1 - t0, 2200);
        wr_en   = 1'b1;
        wr_ch   = 3'd1;
        wr_data = 8'd50;
        measure_frame(-1);
        chk_widths("f2", 8, 10, 518, 28);

        // Out-of-range channel write must not alter any shadow register
        write_pos(3'd5, 8'd77);

        wait_fs(2500, t2, found);
        chk("fs3_seen", found, 1);
        chk("period_f2_f3", t2 - t1, 2200);
        measure_frame(-1);
        chk_widths("f3", 8, 108, 518, 28);

        // Enable drop during ch2: frame completes, then IDLE
        wait_fs(2500, t3, found);
        chk("fs4_seen", found, 1);
        chk("period_f3_f4", t3 - t2, 2200);
        measure_frame(2);
        chk_widths("f4", 8, 108, 518, 28);
        t_idle = 0;
        cnt    = 0;
        while (busy && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        t_idle = cyc;
        chk("busy_fall_time", t_idle - t3, 2200);
        wait_fs(2500, t5, found);
        chk("no_fs_after_drop", found, 0);
        chk("busy_low_after_drop", busy, 0);

        // Asynchronous reset in the middle of ch2's pulse
        enable = 1'b1;
        wait_fs(10, t5, found);
        chk("fs5_seen", found, 1);
        repeat (120) @(negedge clk);
        chk("pre_rst_servo", servo_out, 4'b0100);
        chk("pre_rst_active_ch", active_ch, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_servo", servo_out, 0);
        chk("async_rst_fs", frame_start, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_active_ch", active_ch, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(10, t5, found);
        chk("fs6_seen", found, 1);
        measure_frame(-1);
        chk_widths("f6", 8, 8, 8, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
